// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared synchronous-read memory bus: 6502 CPU plus a
// secondary byte-wide master, with bounded bursts and per-master read-data alignment.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_di,
  input  logic        dma_req,
  input  logic [15:0] dma_ab,
  input  logic        dma_we,
  input  logic [7:0]  dma_do,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_ab,
  output logic        mem_we,
  output logic [7:0]  mem_do,
  input  logic [7:0]  mem_di,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic [3:0]  bcnt;
  logic        own_q;
  logic        rd_q;
  logic [7:0]  di_hold;

  // Grant depends only on the request and registered state, never on mem_di.
  assign dma_gnt = dma_req & (bcnt < BURST_LIM) & ~reset;
  assign cpu_rdy = ~dma_gnt;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    mem_ab = cpu_ab;
    mem_we = cpu_we;
    mem_do = cpu_do;
    if (dma_gnt) begin
      mem_ab = dma_ab;
      mem_we = dma_we;
      mem_do = dma_do;
    end
  end

  // mem_di always carries the data of the previous cycle's owner.
  assign dma_rvalid = own_q & rd_q;
  assign dma_rdata  = mem_di;
  assign cpu_di     = own_q ? di_hold : mem_di;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt      <= 4'd0;
      own_q     <= 1'b0;
      rd_q      <= 1'b0;
      di_hold   <= 8'h00;
      stall_cnt <= 16'h0000;
    end else begin
      bcnt  <= dma_gnt ? bcnt + 4'd1 : 4'd0;
      own_q <= dma_gnt;
      rd_q  <= dma_gnt & ~dma_we;
      // Capture the CPU's own read data so a stalled CPU keeps seeing it.
      if (!own_q) di_hold <= mem_di;
      if (!cpu_rdy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
